// File: rtl/tanh_arbiter.sv
// Round-robin arbiter sharing one tanh unit among NREQ requesters.
// One job at a time: grant in IDLE, start pulse in ISSUE, bounded WAIT, ack in DONE.
module tanh_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] x_in,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      r_out,
  output logic              r_valid,
  output logic              busy,
  output logic              err,
  output logic              u_start,
  output logic [W-1:0]      u_x,
  input  logic              u_ready,
  input  logic [W-1:0]      u_r
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t          r_state, w_state_next;
  logic [PW-1:0]   r_ptr, r_idx, w_off, w_win;
  logic [NREQ-1:0] w_req_rot;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_ux, r_res;
  logic            r_err;
  logic            w_any, w_accept, w_timeout;

  // Requests rotated so bit 0 is the requester at the round-robin pointer.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rot
      assign w_req_rot[gi] = req[r_ptr + PW'(gi)];
      assign ack[gi]       = (r_state == S_DONE) && (r_idx == PW'(gi));
    end
  endgenerate

  always_comb begin
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_req_rot[k]) w_off = PW'(k);
    end
  end

  assign w_any     = |req;
  assign w_win     = r_ptr + w_off;
  // A ready seen in the first WAIT cycle may be left over from a previous job.
  assign w_accept  = (r_state == S_WAIT) && (r_cnt != '0) && u_ready;
  assign w_timeout = (r_state == S_WAIT) && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    u_start      = 1'b0;
    r_valid      = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_any) w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        u_start      = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_accept || w_timeout) w_state_next = S_DONE;
      end
      S_DONE: begin
        r_valid      = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
      r_idx <= '0;
      r_ux  <= '0;
      r_cnt <= '0;
      r_res <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_idx <= w_win;
            r_ux  <= x_in[w_win*W +: W];
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          // A valid ready beats a simultaneous timeout.
          if (w_accept) begin
            r_res <= u_r;
          end else if (w_timeout) begin
            r_res <= '0;
            r_err <= 1'b1;
          end
        end
        S_DONE: r_ptr <= r_idx + PW'(1);
        default: ;
      endcase
    end
  end

  assign r_out = r_res;
  assign u_x   = r_ux;
  assign err   = r_err;

endmodule

// File: doc/tanh_arbiter.md
TANH_ARBITER -- requirements
Module: tanh_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one tanh unit (fixed at 4 for this release).
REQ-002 Parameter W, default 16, operand and result width.
REQ-003 Parameter TIMEOUT, default 64, maximum WAIT cycles before a job is aborted.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 req  in  4  per-requester request level, bit i = requester i.
REQ-007 x_in  in  64  packed operands, x_in[16i+15:16i] = operand of requester i.
REQ-008 ack  out  4  one-hot, one-cycle completion pulse to the served requester.
REQ-009 r_out  out  16  result, valid only while r_valid=1.
REQ-010 r_valid  out  1  one-cycle strobe coincident with ack.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 err  out  1  sticky timeout flag.
REQ-013 u_start  out  1  start pulse to the shared tanh unit.
REQ-014 u_x  out  16  operand bus to the tanh unit.
REQ-015 u_ready  in  1  tanh unit result-valid level.
REQ-016 u_r  in  16  tanh unit result bus.

Function
REQ-017 States: IDLE, ISSUE, WAIT, DONE; encoding free, one state per cycle minimum.
REQ-018 IDLE: if req != 0, select winner by round-robin starting at pointer ptr (2 bits), latch winner index and x_in slice into u_x, go ISSUE; else stay IDLE.
REQ-019 Round-robin: search order ptr, ptr+1, ..., ptr+3 modulo 4; first set req bit wins.
REQ-020 ISSUE: u_start=1 for exactly one cycle, u_x held; go WAIT, clear wait counter.
REQ-021 u_x SHALL stay constant from ISSUE until leaving DONE; changes on x_in meanwhile are ignored.
REQ-022 WAIT: counter increments every cycle; u_ready ignored in first WAIT cycle (guard for stale ready); from second WAIT cycle, u_ready=1 -> capture u_r into r_out, go DONE.
REQ-023 WAIT timeout: counter reaching TIMEOUT with no accepted u_ready -> r_out=16'h0000, err<=1, go DONE.
REQ-024 If u_ready and timeout occur in the same cycle, u_ready wins (result captured, err unchanged).
REQ-025 DONE: ack[idx]=1 and r_valid=1 for one cycle, ptr<=idx+1 (mod 4), go IDLE.
REQ-026 Latency: grant edge to ack = 2 cycles + WAIT cycles; minimum 4 cycles from IDLE sample to ack pulse.
REQ-027 Requester SHALL hold req and operand until ack; req still high in the cycle after ack counts as a new request, arbitrated behind others by ptr.
REQ-028 req deasserted by a requester after being granted does not cancel the job; ack still issued.
REQ-029 busy=0 only in IDLE; no new grant while busy.
REQ-030 err once set stays 1 until reset.

Reset
REQ-031 rst=0 asynchronously forces: state IDLE, ptr=0, ack=0, r_out=0, r_valid=0, busy=0, err=0, u_start=0, u_x=0, counter=0.
REQ-032 Reset during ISSUE/WAIT/DONE aborts the job with no ack; first arbitration after rst release starts at requester 0.

Verification
REQ-033 Single request: req=4'b0001, x0=16'h5555, model returns 16'h3A00 after 5 cycles -> ack=4'b0001 with r_out=16'h3A00, u_start exactly one pulse.
REQ-034 Fairness: req=4'b1111 held continuously for 8 jobs -> ack order 0,1,2,3,0,1,2,3.
REQ-035 Timeout: u_ready stuck 0 -> after 64 WAIT cycles ack pulse, r_out=16'h0000, err=1 persists through later good jobs.
REQ-036 Stale ready: u_ready held 1 at ISSUE -> not accepted in first WAIT cycle; result captured from second WAIT cycle.
REQ-037 Reset mid-WAIT: rst=0 for one cycle during job of requester 2 -> no ack, all outputs 0; subsequent req=4'b0110 served requester 1 first.
REQ-038 Operand hold: x_in changed during WAIT -> u_x unchanged until DONE exits.
